// File: rtl/ibex_mem_arb_pkg.sv
// Shared types and constants for the ibex instruction/data memory arbiter.
//   arb_src_e   : identifies which requester owns a memory transaction
//   arb_state_e : arbiter FSM states
package ibex_mem_arb_pkg;

   typedef enum logic {
      ArbSrcInstr = 1'b0,
      ArbSrcData  = 1'b1
   } arb_src_e;

   typedef enum logic {
      ArbStArb  = 1'b0,
      ArbStHold = 1'b1
   } arb_state_e;

   localparam int unsigned ArbMaxOutstandingLimit = 8;
   // Wide enough to hold 0..ArbMaxOutstandingLimit.
   localparam int unsigned ArbCntW = 4;

   function automatic arb_src_e arb_other(arb_src_e src);
      return (src == ArbSrcInstr) ? ArbSrcData : ArbSrcInstr;
   endfunction

endpackage

// File: rtl/ibex_mem_arb_src_fifo.sv
// In-order FIFO of transaction source IDs (one bit per entry).
//   clk_i, rst_i : clock, async active-high reset
//   push_i       : enqueue push_src_i
//   pop_i        : dequeue head (ignored when empty)
//   head_o       : oldest entry
//   empty_o      : no entries
//   count_o      : number of entries
module ibex_mem_arb_src_fifo
   import ibex_mem_arb_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               push_i,
   input  arb_src_e           push_src_i,
   input  logic               pop_i,
   output arb_src_e           head_o,
   output logic               empty_o,
   output logic [ArbCntW-1:0] count_o
);

   // Shift-down storage: entry 0 is always the head, so Depth=1 needs no pointers.
   logic [Depth-1:0]   mem_q, mem_d;
   logic [ArbCntW-1:0] cnt_q, cnt_d;
   logic [ArbCntW-1:0] wr_idx;
   logic               push_ok, pop_ok, full;

   assign empty_o = (cnt_q == '0);
   assign full    = (cnt_q == ArbCntW'(Depth));
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full | pop_ok);
   assign head_o  = arb_src_e'(mem_q[0]);
   assign count_o = cnt_q;

   always_comb begin
      mem_d  = mem_q;
      cnt_d  = cnt_q;
      wr_idx = pop_ok ? (cnt_q - 4'd1) : cnt_q;
      if (pop_ok) begin
         mem_d = mem_q >> 1;
      end
      for (int i = 0; i < Depth; i++) begin
         if (push_ok && (wr_idx == ArbCntW'(i))) begin
            mem_d[i] = push_src_i;
         end
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 4'd1;
         2'b01:   cnt_d = cnt_q - 4'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between ibex instruction fetch and
// data memory interfaces.
//   clk_i, rst_i        : clock, async active-high reset
//   instr_* / data_*    : requester ports (core side)
//   mem_*               : unified memory port
//   outstanding_o       : granted-but-unresponded transaction count
//   protocol_err_o      : one-cycle pulse after an rvalid with nothing in flight
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ArbStArb  | owner chosen each cycle from live requests
// ArbStHold | request issued but not granted; owner frozen until mem_gnt_i
module ibex_mem_arbiter
   import ibex_mem_arb_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          DataPriority   = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic [6:0]  instr_rdata_intg_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [6:0]  data_wdata_intg_i,
   output logic [31:0] data_rdata_o,
   output logic [6:0]  data_rdata_intg_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [6:0]  mem_wdata_intg_o,
   input  logic [31:0] mem_rdata_i,
   input  logic [6:0]  mem_rdata_intg_i,
   input  logic        mem_err_i,
   output logic [3:0]  outstanding_o,
   output logic        protocol_err_o
);

   localparam logic [ArbCntW-1:0] MaxOut = ArbCntW'(MaxOutstanding);

   arb_state_e         state_q, state_d;
   arb_src_e           owner, owner_q, rr_q, head;
   logic               owner_req, grant, fifo_empty, perr_q;
   logic [ArbCntW-1:0] count;

   ibex_mem_arb_src_fifo #(
      .Depth (MaxOutstanding)
   ) u_src_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (grant),
      .push_src_i (owner),
      .pop_i      (mem_rvalid_i),
      .head_o     (head),
      .empty_o    (fifo_empty),
      .count_o    (count)
   );

   always_comb begin
      if (state_q == ArbStHold) begin
         owner = owner_q;
      end else if (instr_req_i && data_req_i) begin
         owner = DataPriority ? ArbSrcData : rr_q;
      end else if (data_req_i) begin
         owner = ArbSrcData;
      end else begin
         owner = ArbSrcInstr;
      end
   end

   assign owner_req = (owner == ArbSrcData) ? data_req_i : instr_req_i;
   // Registered count only: no combinational path from mem_rvalid_i to mem_req_o.
   assign mem_req_o = owner_req & (count < MaxOut);
   assign grant     = mem_req_o & mem_gnt_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ArbStArb;
         owner_q <= ArbSrcInstr;
         rr_q    <= ArbSrcInstr;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == ArbStArb) && (state_d == ArbStHold)) begin
            owner_q <= owner;
         end
         if (grant) begin
            rr_q <= arb_other(owner);
         end
         perr_q <= mem_rvalid_i & fifo_empty;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ArbStArb:  if (mem_req_o && !mem_gnt_i) state_d = ArbStHold;
         ArbStHold: if (mem_gnt_i) state_d = ArbStArb;
         default:   state_d = ArbStArb;
      endcase
   end

   always_comb begin
      if (owner == ArbSrcData) begin
         mem_we_o         = data_we_i;
         mem_be_o         = data_be_i;
         mem_addr_o       = data_addr_i;
         mem_wdata_o      = data_wdata_i;
         mem_wdata_intg_o = data_wdata_intg_i;
      end else begin
         mem_we_o         = 1'b0;
         mem_be_o         = 4'hF;
         mem_addr_o       = instr_addr_i;
         mem_wdata_o      = '0;
         mem_wdata_intg_o = '0;
      end
      instr_gnt_o    = grant & (owner == ArbSrcInstr);
      data_gnt_o     = grant & (owner == ArbSrcData);
      instr_rvalid_o = mem_rvalid_i & ~fifo_empty & (head == ArbSrcInstr);
      data_rvalid_o  = mem_rvalid_i & ~fifo_empty & (head == ArbSrcData);
   end

   assign instr_rdata_o      = mem_rdata_i;
   assign instr_rdata_intg_o = mem_rdata_intg_i;
   assign instr_err_o        = mem_err_i;
   assign data_rdata_o       = mem_rdata_i;
   assign data_rdata_intg_o  = mem_rdata_intg_i;
   assign data_err_o         = mem_err_i;
   assign outstanding_o      = count;
   assign protocol_err_o     = perr_q;

   // The owner must keep requesting while its request is held ungranted.
   owner_req_held_in_hold: assert property (
      @(posedge clk_i) disable iff (rst_i) (state_q == ArbStHold) |-> owner_req
   );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
module tb_ibex_mem_arbiter;

   localparam int MaxOut = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
   logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
   logic [3:0]  data_be;
   logic [6:0]  data_wdata_intg, mem_rdata_intg;

   logic        o_igant [2], o_irv [2], o_ierr [2], o_dgnt [2], o_drv [2], o_derr [2];
   logic        o_mreq [2], o_mwe [2], o_perr [2];
   logic [31:0] o_irdata [2], o_drdata [2], o_maddr [2], o_mwdata [2];
   logic [6:0]  o_iintg [2], o_dintg [2], o_mwintg [2];
   logic [3:0]  o_mbe [2], o_out [2];

   always #5 clk_i = ~clk_i;

   // Instance 0 uses fixed data priority, instance 1 round-robin; inputs are shared.
   for (genvar p = 0; p < 2; p++) begin : g_dut
      ibex_mem_arbiter #(
         .MaxOutstanding (MaxOut),
         .DataPriority   (p == 0)
      ) u_dut (
         .clk_i              (clk_i),
         .rst_i              (rst_i),
         .instr_req_i        (instr_req),
         .instr_gnt_o        (o_igant[p]),
         .instr_rvalid_o     (o_irv[p]),
         .instr_addr_i       (instr_addr),
         .instr_rdata_o      (o_irdata[p]),
         .instr_rdata_intg_o (o_iintg[p]),
         .instr_err_o        (o_ierr[p]),
         .data_req_i         (data_req),
         .data_gnt_o         (o_dgnt[p]),
         .data_rvalid_o      (o_drv[p]),
         .data_we_i          (data_we),
         .data_be_i          (data_be),
         .data_addr_i        (data_addr),
         .data_wdata_i       (data_wdata),
         .data_wdata_intg_i  (data_wdata_intg),
         .data_rdata_o       (o_drdata[p]),
         .data_rdata_intg_o  (o_dintg[p]),
         .data_err_o         (o_derr[p]),
         .mem_req_o          (o_mreq[p]),
         .mem_gnt_i          (mem_gnt),
         .mem_rvalid_i       (mem_rvalid),
         .mem_we_o           (o_mwe[p]),
         .mem_be_o           (o_mbe[p]),
         .mem_addr_o         (o_maddr[p]),
         .mem_wdata_o        (o_mwdata[p]),
         .mem_wdata_intg_o   (o_mwintg[p]),
         .mem_rdata_i        (mem_rdata),
         .mem_rdata_intg_i   (mem_rdata_intg),
         .mem_err_i          (mem_err),
         .outstanding_o      (o_out[p]),
         .protocol_err_o     (o_perr[p])
      );
   end

   // Reference model: 0 = instr, 1 = data.
   bit m_q [2][$];
   bit m_hold [2], m_hsrc [2], m_rr [2], m_perr [2];
   bit e_own [2], e_mreq [2], e_g [2];
   bit last_ig [2], last_dg [2];
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_q[p].delete();
         m_hold[p] = 0; m_hsrc[p] = 0; m_rr[p] = 0; m_perr[p] = 0;
         last_ig[p] = 0; last_dg[p] = 0;
      end
   endtask

   task automatic idle();
      instr_req = 0; instr_addr = '0; data_req = 0; data_we = 0; data_be = '0;
      data_addr = '0; data_wdata = '0; data_wdata_intg = '0; mem_gnt = 0;
      mem_rvalid = 0; mem_rdata = '0; mem_rdata_intg = '0; mem_err = 0;
   endtask

   task automatic check_all();
      for (int p = 0; p < 2; p++) begin
         bit own, oreq, mreq, g, rv, head;
         if (m_hold[p])                own = m_hsrc[p];
         else if (instr_req && data_req) own = (p == 0) ? 1'b1 : m_rr[p];
         else                          own = data_req;
         oreq = own ? data_req : instr_req;
         mreq = oreq && (m_q[p].size() < MaxOut);
         g    = mreq && mem_gnt;
         rv   = mem_rvalid && (m_q[p].size() > 0);
         head = rv ? m_q[p][0] : 1'b0;
         e_own[p] = own; e_mreq[p] = mreq; e_g[p] = g;
         chk($sformatf("mem_req%0d", p), o_mreq[p], mreq);
         chk($sformatf("instr_gnt%0d", p), o_igant[p], g && !own);
         chk($sformatf("data_gnt%0d", p), o_dgnt[p], g && own);
         chk($sformatf("instr_rvalid%0d", p), o_irv[p], rv && !head);
         chk($sformatf("data_rvalid%0d", p), o_drv[p], rv && head);
         chk($sformatf("outstanding%0d", p), o_out[p], m_q[p].size());
         chk($sformatf("protocol_err%0d", p), o_perr[p], m_perr[p]);
         chk($sformatf("instr_rdata%0d", p), o_irdata[p], mem_rdata);
         chk($sformatf("data_rdata%0d", p), o_drdata[p], mem_rdata);
         chk($sformatf("rdata_intg%0d", p), {o_iintg[p], o_dintg[p]}, {mem_rdata_intg, mem_rdata_intg});
         chk($sformatf("err%0d", p), {o_ierr[p], o_derr[p]}, {mem_err, mem_err});
         if (mreq) begin
            chk($sformatf("mem_addr%0d", p), o_maddr[p], own ? data_addr : instr_addr);
            chk($sformatf("mem_we%0d", p), o_mwe[p], own ? data_we : 1'b0);
            chk($sformatf("mem_be%0d", p), o_mbe[p], own ? data_be : 4'hF);
            chk($sformatf("mem_wdata%0d", p), o_mwdata[p], own ? data_wdata : 32'h0);
            chk($sformatf("mem_wintg%0d", p), o_mwintg[p], own ? data_wdata_intg : 7'h0);
         end
      end
   endtask

   task automatic model_update();
      for (int p = 0; p < 2; p++) begin
         if (mem_rvalid && m_q[p].size() > 0) begin
            void'(m_q[p].pop_front());
            m_perr[p] = 0;
         end else begin
            m_perr[p] = mem_rvalid;
         end
         if (e_g[p]) begin
            m_q[p].push_back(e_own[p]);
            m_rr[p] = !e_own[p];
         end
         if (!m_hold[p] && e_mreq[p] && !mem_gnt) begin
            m_hold[p] = 1; m_hsrc[p] = e_own[p];
         end else if (m_hold[p] && mem_gnt) begin
            m_hold[p] = 0;
         end
         last_ig[p] = e_g[p] && !e_own[p];
         last_dg[p] = e_g[p] && e_own[p];
      end
   endtask

   // Called at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic cyc();
      @(negedge clk_i);
      check_all();
      model_update();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1;
      idle();
      #1;
      chk("rst_outstanding0", o_out[0], 4'd0);
      chk("rst_outstanding1", o_out[1], 4'd0);
      model_reset();
      @(posedge clk_i);
      #1;
      rst_i = 0;
   endtask

   initial begin
      rst_i = 1;
      idle();
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      for (int p = 0; p < 2; p++) begin
         chk("reset_outstanding", o_out[p], 4'd0);
         chk("reset_mem_req", o_mreq[p], 1'b0);
         chk("reset_gnt", {o_igant[p], o_dgnt[p]}, 2'b00);
         chk("reset_rvalid", {o_irv[p], o_drv[p]}, 2'b00);
         chk("reset_err", {o_ierr[p], o_derr[p]}, 2'b00);
         chk("reset_perr", o_perr[p], 1'b0);
      end
      rst_i = 0;

      // Single fetch, response two cycles after the grant.
      instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
      #2;
      for (int p = 0; p < 2; p++) begin
         chk("t1_instr_gnt", o_igant[p], 1'b1);
         chk("t1_mem_we", o_mwe[p], 1'b0);
         chk("t1_mem_be", o_mbe[p], 4'hF);
         chk("t1_mem_addr", o_maddr[p], 32'h100);
      end
      cyc();
      idle();
      cyc();
      mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      #2;
      for (int p = 0; p < 2; p++) begin
         chk("t1_instr_rvalid", o_irv[p], 1'b1);
         chk("t1_instr_rdata", o_irdata[p], 32'hDEADBEEF);
         chk("t1_data_rvalid", o_drv[p], 1'b0);
      end
      cyc();

      // Contention: fixed priority vs round-robin from a fresh pointer.
      do_reset();
      instr_req = 1; instr_addr = 32'h104; data_req = 1; data_addr = 32'h200;
      data_we = 1; data_be = 4'h3; data_wdata = 32'h1234_5678; data_wdata_intg = 7'h15;
      mem_gnt = 1;
      for (int k = 0; k < 3; k++) begin
         mem_rvalid = (k > 0);
         #2;
         chk("t2_prio_data_gnt", o_dgnt[0], 1'b1);
         chk("t2_prio_instr_gnt", o_igant[0], 1'b0);
         chk("t2_rr_instr_gnt", o_igant[1], k != 1);
         chk("t2_rr_data_gnt", o_dgnt[1], k == 1);
         cyc();
      end
      idle(); mem_rvalid = 1;
      cyc();
      idle();

      // Held fetch blocks a later data request until granted.
      instr_req = 1; instr_addr = 32'h300;
      repeat (4) begin
         #2;
         chk("t3_hold_addr0", o_maddr[0], 32'h300);
         chk("t3_hold_addr1", o_maddr[1], 32'h300);
         cyc();
      end
      data_req = 1; data_addr = 32'h400;
      repeat (2) begin
         #2;
         chk("t3_hold_addr", o_maddr[0], 32'h300);
         chk("t3_no_data_gnt", {o_dgnt[0], o_dgnt[1]}, 2'b00);
         cyc();
      end
      mem_gnt = 1;
      #2;
      chk("t3_instr_gnt", {o_igant[0], o_igant[1]}, 2'b11);
      cyc();
      instr_req = 0;
      #2;
      chk("t3_data_gnt", {o_dgnt[0], o_dgnt[1]}, 2'b11);
      cyc();
      idle(); mem_rvalid = 1;
      cyc(); cyc();
      idle();

      // Outstanding limit gating.
      data_req = 1; data_addr = 32'h500; mem_gnt = 1;
      cyc(); cyc();
      #2;
      chk("t4_full_req", o_mreq[0], 1'b0);
      chk("t4_full_cnt", o_out[0], 4'd2);
      cyc();
      mem_rvalid = 1;
      #2;
      chk("t4_req_same_cycle", o_mreq[1], 1'b0);
      cyc();
      mem_rvalid = 0;
      #2;
      chk("t4_req_after_pop", o_mreq[0], 1'b1);
      cyc();
      idle(); mem_rvalid = 1;
      cyc(); cyc();
      idle();

      // Ordered response routing: grants d,i,d; error on the instr response.
      data_req = 1; data_addr = 32'h600; mem_gnt = 1;
      cyc();
      data_req = 0; instr_req = 1; instr_addr = 32'h700;
      cyc();
      instr_req = 0; data_req = 1; data_addr = 32'h604; mem_rvalid = 1; mem_rdata = 32'hA;
      #2;
      chk("t5_rsp1_data", {o_drv[0], o_irv[0]}, 2'b10);
      cyc();
      mem_err = 1; mem_rdata = 32'hB;
      #2;
      chk("t5_rsp2_instr", {o_drv[1], o_irv[1]}, 2'b01);
      chk("t5_rsp2_err", o_ierr[1], 1'b1);
      cyc();
      idle(); mem_rvalid = 1; mem_rdata = 32'hC;
      #2;
      chk("t5_rsp3_data", {o_drv[0], o_irv[0], o_derr[0]}, 3'b100);
      cyc();
      idle();

      // Spurious response and reset with transactions in flight.
      mem_rvalid = 1;
      #2;
      chk("t6_no_rvalid", {o_irv[0], o_drv[0], o_irv[1], o_drv[1]}, 4'b0000);
      cyc();
      idle();
      #2;
      chk("t6_perr_pulse", {o_perr[0], o_perr[1]}, 2'b11);
      cyc();
      #2;
      chk("t6_perr_clear", {o_perr[0], o_perr[1]}, 2'b00);
      cyc();
      data_req = 1; data_addr = 32'h800; mem_gnt = 1;
      cyc(); cyc();
      do_reset();
      mem_rvalid = 1;
      cyc();
      idle();
      #2;
      chk("t6_perr_after_reset", {o_perr[0], o_perr[1]}, 2'b11);
      cyc();

      // Randomized traffic; a pending request stays stable until both instances grant it.
      for (int n = 0; n < 400; n++) begin
         if (!instr_req || (last_ig[0] && last_ig[1])) begin
            instr_req  = ($urandom_range(0, 2) != 0);
            instr_addr = $urandom();
         end
         if (!data_req || (last_dg[0] && last_dg[1])) begin
            data_req        = ($urandom_range(0, 2) != 0);
            data_addr       = $urandom();
            data_we         = $urandom_range(0, 1);
            data_be         = $urandom_range(0, 15);
            data_wdata      = $urandom();
            data_wdata_intg = $urandom_range(0, 127);
         end
         mem_gnt = ($urandom_range(0, 2) != 0);
         if (m_q[0].size() > 0) mem_rvalid = $urandom_range(0, 1);
         else                   mem_rvalid = ($urandom_range(0, 9) == 0);
         mem_rdata      = $urandom();
         mem_rdata_intg = $urandom_range(0, 127);
         mem_err        = ($urandom_range(0, 7) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
